// File: rtl/bsg_lfsr_prng.sv
// Galois LFSR pseudo-random word source with seed load, optional warm-up
// and a wrap pulse when the sequence returns to the active seed.
module bsg_lfsr_prng #(
   parameter int unsigned width_p    = 32,
   parameter logic [63:0] taps_p     = 64'h2600_0000,
   parameter logic [63:0] init_val_p = 64'd1,
   parameter int unsigned steps_p    = 1,
   parameter int unsigned warmup_p   = 0
) (
   input  logic               clk,
   input  logic               reset_i,
   input  logic               seed_v_i,
   input  logic [width_p-1:0] seed_i,
   input  logic               yumi_i,
   output logic               v_o,
   output logic [width_p-1:0] o,
   output logic               wrap_o
);

   typedef enum logic [0:0] {StWarm, StRun} state_e;

   localparam logic [width_p-1:0] InitVal   = init_val_p[width_p-1:0];
   localparam logic [7:0]         WarmupCnt = 8'(warmup_p);
   localparam state_e             StStart   = (warmup_p == 0) ? StRun : StWarm;

   state_e             state_q;
   logic [width_p-1:0] o_q;
   logic [width_p-1:0] seed_q;
   logic [7:0]         cnt_q;
   logic               wrap_q;

   logic [width_p-1:0] adv;
   logic [width_p-1:0] seed_sel;
   logic [7:0]         cnt_inc;

   // One Galois step: the bit shifted out feeds the MSB and every tapped bit.
   function automatic logic [width_p-1:0] lfsr_step(input logic [width_p-1:0] s);
      logic [width_p-1:0] n;
      n[width_p-1] = s[0];
      for (int i = 0; i < int'(width_p) - 1; i++) begin
         n[i] = s[i+1] ^ (s[0] & taps_p[i]);
      end
      return n;
   endfunction

   always_comb begin
      adv = o_q;
      for (int k = 0; k < int'(steps_p); k++) begin
         adv = lfsr_step(adv);
      end
      // An all-zero seed would lock the LFSR, so substitute the init value.
      seed_sel = (seed_i == '0) ? InitVal : seed_i;
      cnt_inc  = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StStart;
         o_q     <= InitVal;
         seed_q  <= InitVal;
         cnt_q   <= 8'd0;
         wrap_q  <= 1'b0;
      end else if (seed_v_i) begin
         state_q <= StStart;
         o_q     <= seed_sel;
         seed_q  <= seed_sel;
         cnt_q   <= 8'd0;
         wrap_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StWarm: begin
               o_q    <= adv;
               cnt_q  <= cnt_inc;
               wrap_q <= (adv == seed_q);
               if (cnt_inc == WarmupCnt) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (yumi_i) begin
                  o_q    <= adv;
                  wrap_q <= (adv == seed_q);
               end else begin
                  wrap_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign v_o    = (state_q == StRun);
   assign o      = o_q;
   assign wrap_o = wrap_q;

endmodule

// File: doc/bsg_lfsr_prng.md
BSG_LFSR_PRNG -- requirements
Module: bsg_lfsr_prng

Interface
- REQ-001 Parameter width_p, default 32, meaning LFSR state and output width; legal range 4..64.
- REQ-002 Parameter taps_p, default 32'h2600_0000, meaning Galois tap mask: bit i set means o[0] is XORed into next-state bit i; bit width_p-1 is ignored.
- REQ-003 Parameter init_val_p, default 1, meaning the nonzero state loaded at reset and substituted for an all-zero seed.
- REQ-004 Parameter steps_p, default 1, meaning the number of single LFSR steps applied per advance; legal range 1..width_p.
- REQ-005 Parameter warmup_p, default 0, meaning the number of advances the block performs by itself after reset or seed load before it presents output; legal range 0..255.
- REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-007 Port reset_i, input, 1 bit: asynchronous, active-high reset.
- REQ-008 Port seed_v_i, input, 1 bit: load seed_i this cycle.
- REQ-009 Port seed_i, input, width_p bits: seed value.
- REQ-010 Port yumi_i, input, 1 bit: consumer accepts o this cycle; legal only while v_o=1.
- REQ-011 Port v_o, output, 1 bit: o holds a valid pseudo-random word.
- REQ-012 Port o, output, width_p bits: current LFSR state.
- REQ-013 Port wrap_o, output, 1 bit: registered one-cycle pulse; the sequence returned to the active seed.

Function
- REQ-014 A single step SHALL compute n[width_p-1]=o[0] and n[i]=o[i+1]^(o[0]&taps_p[i]) for i<width_p-1.
- REQ-015 An advance SHALL apply steps_p chained single steps combinationally within one cycle.
- REQ-016 The block SHALL have two states, WARM and RUN, with v_o=1 exactly in RUN.
- REQ-017 In WARM the block SHALL advance o every cycle, count advances, and enter RUN on the cycle the count reaches warmup_p; yumi_i SHALL be ignored.
- REQ-018 In RUN, yumi_i=1 SHALL advance o at the next edge; yumi_i=0 SHALL hold o.
- REQ-019 seed_v_i=1 SHALL take priority over yumi_i and warmup in any state.
- REQ-020 On seed load the block SHALL set o and the stored active seed to seed_i, or to init_val_p if seed_i==0.
- REQ-021 On seed load the block SHALL clear the warmup count and enter WARM, or enter RUN directly if warmup_p==0; any coincident yumi_i is discarded.
- REQ-022 wrap_o SHALL be 1 for the cycle after an advance whose result equals the active seed, and 0 otherwise; a seed load SHALL not assert wrap_o.
- REQ-023 With steps_p>1, wrap_o SHALL fire only when an advance lands exactly on the active seed.
- REQ-024 The all-zero state SHALL be unreachable.

Reset
- REQ-025 While reset_i=1 (asynchronously), o=init_val_p, active seed=init_val_p, warmup count=0, and wrap_o=0.
- REQ-026 While reset_i=1, state=WARM (v_o=0) if warmup_p>0, else state=RUN (v_o=1).
- REQ-027 Reset asserted mid-warmup or mid-sequence SHALL abandon all progress.
- REQ-028 A seed_v_i or yumi_i coincident with reset SHALL be ignored.

Verification
- REQ-029 Default parameters, reset, one yumi: o goes 32'h0000_0001 -> 32'hA600_0000.
- REQ-030 width_p=4, taps_p=4'h4, yumi held high: o follows 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1; wrap_o pulses once, on the cycle o returns to 1; the period is 15.
- REQ-031 width_p=4, taps_p=4'h4, warmup_p=3: v_o=0 for 3 cycles after reset release, then v_o=1 with o=4'h3; yumi during warmup has no effect.
- REQ-032 width_p=4, taps_p=4'h4, steps_p=2: from o=1 one yumi gives o=4'h6; a seed load of 4'h0 gives o=init_val_p=1.
- REQ-033 Seed load of 4'hD with yumi_i=1 in the same cycle: next o=4'hD, no advance; wrap_o pulses on the 15th subsequent yumi.
- REQ-034 reset_i pulsed asynchronously between edges mid-warmup: o=init_val_p immediately, warmup restarts in full.
